// File: rtl/fifo_delay_pkg.sv
// Shared constants for the fifo delay-line controller: default fifo geometry,
// FSM state encoding and the delay_len acceptance rule.
package fifo_delay_pkg;

    localparam int DEPTH_DEFAULT     = 87;
    localparam int CNT_WIDTH_DEFAULT = 7;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRIME = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_FLUSH = 3'd4;

    // A full fifo refuses writes even with a concurrent read, so DEPTH itself is unusable.
    function automatic logic delay_len_ok(input int unsigned len, input int unsigned depth);
        return (len >= 32'd1) && (len < depth);
    endfunction

endpackage

// File: rtl/fifo_delay_ctrl_if.sv
// Command, stream-qualifier and fifo-control bundle of the delay-line controller.
// The controller is the slave; the host/testbench side is the master.
interface fifo_delay_ctrl_if
    import fifo_delay_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
);
    logic                 start;
    logic                 stop;
    logic                 flush;
    logic [CNT_WIDTH-1:0] delay_len;
    logic                 in_valid;
    logic                 fifo_wr_en;
    logic                 fifo_rd_en;
    logic                 fifo_rst;
    logic                 out_valid;
    logic                 busy;
    logic [CNT_WIDTH-1:0] level;
    logic                 cfg_err;
    logic                 overrun;

    modport slave (
        input  start, stop, flush, delay_len, in_valid,
        output fifo_wr_en, fifo_rd_en, fifo_rst, out_valid, busy, level, cfg_err, overrun
    );

    modport master (
        output start, stop, flush, delay_len, in_valid,
        input  fifo_wr_en, fifo_rd_en, fifo_rst, out_valid, busy, level, cfg_err, overrun
    );
endinterface

// File: rtl/fifo_delay_ctrl.sv
// Sequencer running an external fifo as a programmable fixed-latency delay line.
// Optional sticky input-drop detection is built when FIFO_DELAY_OVERRUN_EN is defined.
module fifo_delay_ctrl
    import fifo_delay_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEFAULT,
    parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    fifo_delay_ctrl_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] LVL_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] LVL_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] level_q, level_d;
    logic [CNT_WIDTH-1:0] delay_q, delay_d;
    logic                 out_valid_q, out_valid_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 wr_en_s, rd_en_s, start_ok_s;
    logic [CNT_WIDTH-1:0] level_inc_s;

    assign level_inc_s = level_q + LVL_ONE;
    assign start_ok_s  = (state_q == ST_IDLE) && bus.start && !bus.flush &&
                         delay_len_ok(32'(bus.delay_len), 32'(DEPTH));

    // fifo strobes; forced low while reset is asserted
    always_comb begin
        wr_en_s = 1'b0;
        rd_en_s = 1'b0;
        if (rst) begin
            wr_en_s = 1'b0;
            rd_en_s = 1'b0;
        end else begin
            case (state_q)
                ST_PRIME: wr_en_s = bus.in_valid && (level_q < delay_q);
                ST_RUN: begin
                    wr_en_s = bus.in_valid;
                    rd_en_s = bus.in_valid;
                end
                ST_DRAIN: rd_en_s = (level_q != LVL_ZERO);
                default: begin
                    wr_en_s = 1'b0;
                    rd_en_s = 1'b0;
                end
            endcase
        end
    end

    // level mirrors fifo occupancy from the strobes actually issued
    always_comb begin
        level_d = level_q;
        if (state_q == ST_FLUSH) begin
            level_d = LVL_ZERO;
        end else if (wr_en_s && !rd_en_s) begin
            level_d = level_inc_s;
        end else if (rd_en_s && !wr_en_s) begin
            level_d = level_q - LVL_ONE;
        end else begin
            level_d = level_q;
        end
    end

    // FSM and delay latch; flush overrides every other command
    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        cfg_err_d = 1'b0;
        if (bus.flush) begin
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        state_d = ST_PRIME;
                        delay_d = bus.delay_len;
                    end else if (bus.start) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        cfg_err_d = 1'b0;
                    end
                end
                ST_PRIME: begin
                    if (bus.stop) begin
                        state_d = ST_DRAIN;
                    end else if (wr_en_s && (level_inc_s == delay_q)) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PRIME;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (level_q <= LVL_ONE) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_FLUSH: state_d = ST_IDLE;
                default: begin
                    state_d = ST_IDLE;
                    delay_d = LVL_ZERO;
                end
            endcase
        end
    end

    assign out_valid_d = rd_en_s;

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            level_q     <= LVL_ZERO;
            delay_q     <= LVL_ZERO;
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            delay_q     <= delay_d;
            out_valid_q <= out_valid_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

`ifdef FIFO_DELAY_OVERRUN_EN
    logic overrun_q, overrun_d;

    // sticky drop flag: a sample offered while the fifo is not being written
    always_comb begin
        overrun_d = overrun_q;
        if (start_ok_s) begin
            overrun_d = 1'b0;
        end else if (bus.in_valid && ((state_q == ST_IDLE) || (state_q == ST_DRAIN) ||
                                      (state_q == ST_FLUSH))) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // overrun register
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign bus.overrun = overrun_q;
`else
    assign bus.overrun = 1'b0;
`endif

    assign bus.fifo_wr_en = wr_en_s;
    assign bus.fifo_rd_en = rd_en_s;
    assign bus.fifo_rst   = rst | (state_q == ST_FLUSH);
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.level      = level_q;
    assign bus.cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_fifo_delay_ctrl.sv
// Self-checking bench: controller plus a behavioural 87x16 fifo; every sample fed is
// expected back in order, with latency delay+1 under continuous input.
module tb_fifo_delay_ctrl;
    import fifo_delay_pkg::*;

    localparam int DEPTH = DEPTH_DEFAULT;
    localparam int CW    = CNT_WIDTH_DEFAULT;
`ifdef FIFO_DELAY_OVERRUN_EN
    localparam logic OVR_EN = 1'b1;
`else
    localparam logic OVR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_delay_ctrl_if #(.CNT_WIDTH(CW)) bus ();
    fifo_delay_ctrl #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // behavioural fifo: registered buf_out, refuses writes when full
    logic [15:0] buf_in, buf_out;
    logic [15:0] fq[$];
    int          full_hits = 0;
    always @(posedge clk) begin
        if (bus.fifo_rst) begin
            fq.delete();
            buf_out <= 16'd0;
        end else begin
            if (bus.fifo_wr_en && fq.size() == DEPTH) full_hits++;
            if (bus.fifo_rd_en && fq.size() > 0) buf_out <= fq.pop_front();
            if (bus.fifo_wr_en && fq.size() < DEPTH) fq.push_back(buf_in);
        end
    end

    int          n_checks = 0, n_fail = 0;
    int          cyc = 0, n_rd = 0, n_wr = 0;
    bit          mon_en = 1'b0, feeding = 1'b0, lat_chk = 1'b0;
    int          exp_d = 0;
    logic [15:0] sb_data[$];
    int          sb_cyc[$];
    logic [15:0] seq = 16'd1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // monitor and scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (mon_en) begin
            chk("level_mirror", 32'(bus.level), 32'(fq.size()));
            if (bus.fifo_wr_en) n_wr++;
            if (bus.fifo_rd_en) begin
                n_rd++;
                chk("rd_nonempty", 32'(bus.level != '0), 32'd1);
            end
            if (feeding) chk("wr_follows_valid", 32'(bus.fifo_wr_en), 32'(bus.in_valid));
            if (feeding && bus.in_valid) begin
                sb_data.push_back(buf_in);
                sb_cyc.push_back(cyc);
            end
            if (bus.out_valid) begin
                chk("sb_has_data", 32'(sb_data.size() > 0), 32'd1);
                if (sb_data.size() > 0) begin
                    logic [15:0] d;
                    int          c;
                    d = sb_data.pop_front();
                    c = sb_cyc.pop_front();
                    chk("data_order", 32'(buf_out), 32'(d));
                    if (lat_chk) chk("latency", 32'(cyc - c), 32'(exp_d + 1));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input int len);
        bus.start     = 1'b1;
        bus.delay_len = CW'(len);
        tick();
        bus.start = 1'b0;
        chk("start_busy", 32'(bus.busy), 32'd1);
        chk("start_no_cfg_err", 32'(bus.cfg_err), 32'd0);
    endtask

    task automatic feed(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            buf_in       = seq;
            seq          = seq + 16'd1;
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    // stop from RUN at level d: exactly d reads, IDLE right after the last one
    task automatic stop_drain(input int d);
        int rd0;
        feeding      = 1'b0;
        lat_chk      = 1'b0;
        bus.in_valid = 1'b0;
        bus.stop     = 1'b1;
        tick();
        bus.stop = 1'b0;
        rd0      = n_rd;
        repeat (d - 1) tick();
        chk("drain_busy_before_last", 32'(bus.busy), 32'd1);
        tick();
        chk("drain_idle", 32'(bus.busy), 32'd0);
        chk("drain_level", 32'(bus.level), 32'd0);
        chk("drain_reads", 32'(n_rd - rd0), 32'(d));
        tick();
        chk("drain_all_out", 32'(sb_data.size()), 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && bus.busy; i++) tick();
        chk("idle_in_budget", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int bad_lens[3] = '{0, 87, 127};
        int wr0, rd0;
        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.flush = 1'b0;
        bus.delay_len = '0; bus.in_valid = 1'b1; buf_in = 16'd0;
        tick(); tick();
        chk("rst_fifo_rst", 32'(bus.fifo_rst), 32'd1);
        chk("rst_wr", 32'(bus.fifo_wr_en), 32'd0);
        chk("rst_rd", 32'(bus.fifo_rd_en), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        rst = 1'b0; bus.in_valid = 1'b0;
        tick();
        mon_en = 1'b1;

        // delay 5, continuous samples 1,2,3...
        seq = 16'd1; exp_d = 5; lat_chk = 1'b1;
        start_cmd(5);
        feeding = 1'b1;
        feed(20, 1'b0);
        chk("t1_level", 32'(bus.level), 32'd5);
        stop_drain(5);

        // rejected delay lengths
        wr0 = n_wr; rd0 = n_rd;
        foreach (bad_lens[k]) begin
            bus.start = 1'b1; bus.delay_len = CW'(bad_lens[k]);
            tick();
            bus.start = 1'b0;
            chk("cfg_err_pulse", 32'(bus.cfg_err), 32'd1);
            chk("cfg_err_busy", 32'(bus.busy), 32'd0);
            tick();
            chk("cfg_err_single", 32'(bus.cfg_err), 32'd0);
            chk("cfg_err_busy2", 32'(bus.busy), 32'd0);
        end
        chk("cfg_err_no_wr", 32'(n_wr - wr0), 32'd0);
        chk("cfg_err_no_rd", 32'(n_rd - rd0), 32'd0);

        // maximum delay 86, 300 continuous samples
        exp_d = 86; lat_chk = 1'b1;
        start_cmd(86);
        feeding = 1'b1;
        feed(300, 1'b0);
        chk("t2_level", 32'(bus.level), 32'd86);
        chk("t2_never_full", 32'(full_hits), 32'd0);
        stop_drain(86);

        // random in_valid, delay 10
        exp_d = 10; lat_chk = 1'b0;
        start_cmd(10);
        feeding = 1'b1;
        feed(200, 1'b1);
        feed(12, 1'b0);
        chk("rand_level", 32'(bus.level), 32'd10);
        stop_drain(10);

        // flush beats a same-cycle stop in PRIME at level 3
        exp_d = 6; lat_chk = 1'b0;
        start_cmd(6);
        feeding = 1'b1;
        feed(3, 1'b0);
        feeding = 1'b0;
        chk("flush_pre_level", 32'(bus.level), 32'd3);
        bus.flush = 1'b1; bus.stop = 1'b1;
        tick();
        bus.flush = 1'b0; bus.stop = 1'b0;
        sb_data.delete(); sb_cyc.delete();
        chk("flush_fifo_rst", 32'(bus.fifo_rst), 32'd1);
        chk("flush_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("flush_fifo_rst_end", 32'(bus.fifo_rst), 32'd0);
        chk("flush_idle", 32'(bus.busy), 32'd0);
        chk("flush_level", 32'(bus.level), 32'd0);
        exp_d = 2; lat_chk = 1'b1;
        start_cmd(2);
        feeding = 1'b1;
        feed(10, 1'b0);
        stop_drain(2);

        // reset in RUN with in_valid high
        exp_d = 4; lat_chk = 1'b1;
        start_cmd(4);
        feeding = 1'b1;
        feed(10, 1'b0);
        feeding = 1'b0; lat_chk = 1'b0;
        bus.in_valid = 1'b1; rst = 1'b1;
        #1;
        chk("run_rst_wr", 32'(bus.fifo_wr_en), 32'd0);
        chk("run_rst_rd", 32'(bus.fifo_rd_en), 32'd0);
        chk("run_rst_fifo_rst", 32'(bus.fifo_rst), 32'd1);
        tick();
        rst = 1'b0; bus.in_valid = 1'b0;
        sb_data.delete(); sb_cyc.delete();
        chk("run_rst_busy", 32'(bus.busy), 32'd0);
        chk("run_rst_level", 32'(bus.level), 32'd0);
        chk("run_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("run_rst_fifo_empty", 32'(fq.size()), 32'd0);

        // dropped input during DRAIN; accepted start clears the sticky flag
        exp_d = 3; lat_chk = 1'b0;
        start_cmd(3);
        feeding = 1'b1;
        feed(8, 1'b0);
        feeding = 1'b0;
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("overrun_set", 32'(bus.overrun), 32'(OVR_EN));
        wait_idle(10);
        tick();
        chk("overrun_drain_out", 32'(sb_data.size()), 32'd0);
        chk("overrun_sticky", 32'(bus.overrun), 32'(OVR_EN));
        start_cmd(3);
        chk("overrun_cleared", 32'(bus.overrun), 32'd0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        wait_idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_delay_ctrl.md
Name: fifo_delay_ctrl

Overview:
Control-only sequencer that runs the 16-bit, 87-entry fifo as a programmable fixed-latency delay line for the sample stream.
- Drives the fifo's wr_en, rd_en and rst; data goes straight from the upstream source to buf_in and from buf_out to downstream, never through this block.
- Primes the fifo to a programmed depth, then streams one read per write, and drains or flushes on command.
- Flags an out_valid aligned with buf_out.

Parameters:
DEPTH, 87, fifo entry count (must match the fifo's buffer size)
CNT_WIDTH, 7, width of level and delay_len; must satisfy 2^CNT_WIDTH > DEPTH

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; latch delay_len and begin priming
stop  in  1  one-cycle pulse; end input acceptance and drain
flush  in  1  one-cycle pulse; discard fifo contents
delay_len  in  CNT_WIDTH  requested delay in samples, sampled on start
in_valid  in  1  upstream sample present on fifo buf_in this cycle
fifo_wr_en  out  1  to fifo wr_en
fifo_rd_en  out  1  to fifo rd_en
fifo_rst  out  1  to fifo rst
out_valid  out  1  fifo buf_out holds a new delayed sample this cycle
busy  out  1  state != IDLE
level  out  CNT_WIDTH  mirrored fifo occupancy
cfg_err  out  1  one-cycle pulse: rejected delay_len
overrun  out  1  sticky input-dropped flag (see Optional Feature)

Behaviour:
Reset:
- Synchronous reset sets state=IDLE, level=0, delay_reg=0, and clears out_valid, cfg_err and overrun.
- fifo_rst = rst OR (state==FLUSH); it is combinational, so the fifo clears in the same cycles.
- fifo_wr_en and fifo_rd_en are combinational from state and in_valid, so they are 0 during reset.
- Command priority, highest first: rst > flush > stop > start.

States:
- IDLE: wr=rd=0. On start with 1 <= delay_len <= DEPTH-1: latch delay_reg and go to PRIME. On start with delay_len==0 or >= DEPTH: pulse cfg_err for one cycle and stay in IDLE.
  - DEPTH itself is excluded because the fifo refuses a write when full, even with a concurrent read. With a full fifo, RUN would silently lose samples.
- PRIME: fifo_wr_en=in_valid, rd=0, level increments per write. Go to RUN on the edge where level becomes delay_reg; the comparison uses the next-level value.
- RUN: fifo_wr_en=fifo_rd_en=in_valid. Level holds at delay_reg, so the fifo is never empty or full.
- DRAIN: wr=0, fifo_rd_en=1 while level>0, level decrements. When level reaches 0, go to IDLE; the last read's out_valid still fires one cycle later.
- FLUSH: one cycle with fifo_rst=1, wr=rd=0, level<=0. Then go to IDLE.

Commands by state:
- stop in PRIME or RUN goes to DRAIN. stop in IDLE, DRAIN or FLUSH is ignored.
- flush from any state goes to FLUSH, overriding a same-cycle stop or start.
- start outside IDLE is ignored; delay_reg is never changed mid-stream.

Timing and arithmetic:
- out_valid is registered fifo_rd_en: 1-cycle latency, matching the fifo's registered buf_out.
- Delay in accepted samples = delay_reg. With continuous in_valid, a sample written at cycle t is valid at cycle t+delay_reg+1.
- Level arithmetic is unsigned CNT_WIDTH. It never wraps: increment only in PRIME while below delay_reg, decrement only in DRAIN while above 0.
- fifo_rd_en is never asserted with level==0, and fifo_wr_en is never asserted with level>=DEPTH-1 outside RUN.

Optional Feature:
FIFO_DELAY_OVERRUN_EN
- Defined: overrun sets when in_valid=1 while state is IDLE, DRAIN or FLUSH (sample not written). It stays set until rst or an accepted start.
- Undefined: overrun is tied to 0 and no detection logic is built.

Decomposition:
Shared package fifo_delay_pkg holds:
- state encoding constants ST_IDLE, ST_PRIME, ST_RUN, ST_DRAIN, ST_FLUSH (3 bits);
- DEPTH and CNT_WIDTH defaults, shared with the fifo's size/width defines.

No sub-module is needed: the FSM, level counter and out_valid register live in one module. The bench instantiates fifo_delay_ctrl together with the existing fifo.

Test Plan:
- start, delay_len=5, in_valid held high with data 1,2,3... -> PRIME for 5 writes; out_valid first high 6 cycles after the first write with buf_out=1; buf_out=k+... in order, level stays 5.
- start, delay_len=86, continuous input for 300 samples -> level peaks at 86, no sample lost, no fifo full ever, output sequence equals input delayed by 86.
- start with delay_len=0, then with 87 -> cfg_err is a single-cycle pulse each time, busy stays 0, no fifo activity.
- RUN at level=5, then stop -> exactly 5 reads with out_valid; IDLE with level=0 on the cycle after the 5th read; the remaining data is the last 5 inputs.
- flush asserted mid-PRIME at level=3, same cycle as stop -> FLUSH wins; fifo_rst high for 1 cycle, level=0, then IDLE; a following start/delay 2 yields correct fresh data.
- rst high during RUN -> next cycle state IDLE, outputs 0, fifo cleared. With FIFO_DELAY_OVERRUN_EN, in_valid during DRAIN sets overrun, and a new accepted start clears it.
